// File: rtl/traffic_display.sv
// traffic_display: scans four lights' remaining time onto a 4-digit 7-seg display with change flashing
module traffic_display #(
   parameter int BLINK_HALF = 96,
   parameter int FLASH_LOAD = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic [3:0]  color,
   input  logic [15:0] time_in,
   output logic [7:0]  seg,
   output logic [3:0]  an
);
   logic [1:0] scan_idx, scan_nxt;
   logic [7:0] blink_div;
   logic       blink_tick, live, blank;
   logic [3:0] prev_color, chg, digit;
   logic [7:0] seg_nxt;
   logic [2:0] flash_cnt [4];
   logic [2:0] flash_nxt [4];

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // Scan advance, blink tick, change detect and the segment byte for the digit selected after this edge
   always_comb begin
      scan_nxt   = clk_en ? scan_idx + 2'd1 : scan_idx;
      blink_tick = clk_en && (blink_div == 8'(BLINK_HALF - 1));
      chg        = color ^ prev_color;
      digit      = time_in[{scan_nxt, 2'b00} +: 4];
      blank      = (flash_cnt[scan_nxt] != 3'd0) && !flash_cnt[scan_nxt][0];
      seg_nxt    = blank ? 8'hFF : {~color[scan_nxt], hex7(digit)};
   end

   // Per-light flash counter: a color change reloads, otherwise count down one step per blink tick
   always_comb begin
      for (int i = 0; i < 4; i++)
         flash_nxt[i] = chg[i] ? 3'(FLASH_LOAD)
                      : (blink_tick && flash_cnt[i] != 3'd0) ? flash_cnt[i] - 3'd1
                      : flash_cnt[i];
   end

   // State and registered display outputs; display stays dark until the first scan tick
   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_idx   <= 2'd0;
         blink_div  <= 8'd0;
         prev_color <= color;
         live       <= 1'b0;
         seg        <= 8'hFF;
         an         <= 4'hF;
         for (int i = 0; i < 4; i++) flash_cnt[i] <= 3'd0;
      end else begin
         scan_idx   <= scan_nxt;
         prev_color <= color;
         live       <= live | clk_en;
         if (clk_en) blink_div <= blink_tick ? 8'd0 : blink_div + 8'd1;
         if (live || clk_en) begin
            an  <= ~(4'b0001 << scan_nxt);
            seg <= seg_nxt;
         end
         for (int i = 0; i < 4; i++) flash_cnt[i] <= flash_nxt[i];
      end
   end
endmodule

// File: tb/tb_traffic_display.sv
// tb_traffic_display: directed checks of scan, digit coding, dp, flash, retrigger and reset behaviour
module tb_traffic_display;
   logic        clk = 1'b0;
   logic        rst, clk_en;
   logic [3:0]  color;
   logic [15:0] time_in;
   logic [7:0]  seg;
   logic [3:0]  an;
   int          n_assert = 0;
   int          n_fail = 0;

   traffic_display #(.BLINK_HALF(2), .FLASH_LOAD(6)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .color(color),
      .time_in(time_in), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   task automatic step(input logic en);
      clk_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fc(input int k);
      return {5'd0, dut.flash_cnt[k]};
   endfunction

   function automatic logic [7:0] fc_any();
      return {5'd0, dut.flash_cnt[0] | dut.flash_cnt[1] | dut.flash_cnt[2] | dut.flash_cnt[3]};
   endfunction

   initial begin
      logic [3:0] scan_an [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
      logic [7:0] scan_seg [5] = '{8'hF9, 8'hA4, 8'hB0, 8'hC0, 8'hF9};
      logic [2:0] f2_seq [12] = '{3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
      logic [3:0] code_an [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      logic [7:0] code_seg [4] = '{8'h8E, 8'h08, 8'h03, 8'h80};
      rst = 1'b0; clk_en = 1'b0; color = 4'hF; time_in = 16'h3210;
      repeat (3) step(1'b0);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_an", {4'h0, an}, 8'h0F);
      rst = 1'b1;
      step(1'b0);
      step(1'b0);
      chk("idle_an", {4'h0, an}, 8'h0F);
      chk("idle_seg", seg, 8'hFF);
      chk("idle_noflash", fc_any(), 8'h00);
      color = 4'h0; rst = 1'b0;
      step(1'b0);
      rst = 1'b1;
      step(1'b0);
      chk("rst_prev_color", fc_any(), 8'h00);
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         chk($sformatf("scan_an%0d", i), {4'h0, an}, {4'h0, scan_an[i]});
         chk($sformatf("scan_seg%0d", i), seg, scan_seg[i]);
      end
      time_in = 16'h3270;
      step(1'b0);
      chk("latency_seg", seg, 8'hF8);
      color = 4'b0100;
      step(1'b0);
      chk("flash2_load", fc(2), 8'd6);
      for (int i = 0; i < 12; i++) begin
         step(1'b1);
         chk($sformatf("flash2_cnt%0d", i), fc(2), {5'd0, f2_seq[i]});
         if (an == 4'b1011) chk($sformatf("flash2_blank%0d", i), seg, 8'hFF);
      end
      step(1'b1);
      chk("flash2_done_an", {4'h0, an}, 8'h0B);
      chk("flash2_done_seg", seg, 8'h24);
      repeat (3) step(1'b1);
      color = 4'b0101; time_in = 16'h3275;
      step(1'b0);
      repeat (3) step(1'b1);
      chk("odd_phase_an", {4'h0, an}, 8'h0E);
      chk("odd_phase_seg", seg, 8'h12);
      repeat (8) step(1'b1);
      chk("flash0_zero", fc(0), 8'd0);
      repeat (4) step(1'b1);
      chk("green5_an", {4'h0, an}, 8'h0E);
      chk("green5_seg", seg, 8'h12);
      color = 4'b0111;
      step(1'b0);
      chk("retrig_load", fc(1), 8'd6);
      step(1'b1);
      chk("retrig_blank_an", {4'h0, an}, 8'h0D);
      chk("retrig_blank_seg", seg, 8'hFF);
      repeat (5) step(1'b1);
      chk("retrig_at3", fc(1), 8'd3);
      step(1'b1);
      color = 4'b0101;
      step(1'b1);
      chk("retrig_wins", fc(1), 8'd6);
      color = 4'b1100;
      step(1'b0);
      chk("multi_f3", fc(3), 8'd6);
      chk("multi_f0", fc(0), 8'd6);
      repeat (4) step(1'b1);
      chk("midflash_f3", fc(3), 8'd4);
      rst = 1'b0;
      step(1'b1);
      chk("midrst_flash", fc_any(), 8'h00);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_an", {4'h0, an}, 8'h0F);
      rst = 1'b1;
      step(1'b0);
      chk("postrst_an", {4'h0, an}, 8'h0F);
      time_in = 16'hBAF8;
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         chk($sformatf("code_an%0d", i), {4'h0, an}, {4'h0, code_an[i]});
         chk($sformatf("code_seg%0d", i), seg, code_seg[i]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/traffic_display.md
# traffic_display

Display stage downstream of the four traffic-light controllers on the Nexys3 top level. It consumes each light's current color and remaining-time count and drives the shared four-digit seven-segment display. Digit k shows light k's remaining time in hex, with the decimal point lit while that light is green. When a light changes color, its digit flashes for three blink periods.

## Interface
Parameters:
- `BLINK_HALF`, default 96: `clk_en` ticks per blink half-period. Legal range is 2..255.
- `FLASH_LOAD`, default 6: flash counter reload value. Gives three blank phases.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-low reset. `rst`=0 at a rising `clk` edge resets the block.
- `clk_en`  in  1  one-cycle scan tick from the top-level divider (~763 Hz).
- `color`  in  4  bit k is light k's color: 1 = green, 0 = red.
- `time_in`  in  16  `time_in[4k+3:4k]` is light k's remaining time, 0..15.
- `seg`  out  8  segment drive, active-low. `seg[6:0]` = g..a; `seg[7]` = dp.
- `an`  out  4  digit anodes, active-low, one-hot low. `an[k]` selects light k.

## Operation
- Scan:
  - 2-bit `scan_idx` increments, wrapping 3->0, on each `clk` edge with `clk_en`=1.
  - `an` and `seg` are registered and always reflect the post-update `scan_idx` on the same edge.
  - `an = ~(4'b0001 << scan_idx)`.
- Digit pattern for light k, active-low `{g..a}`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
  - `seg[7] = ~color[k]`.
  - Full byte examples: red 5 = 8'h92; green 5 = 8'h12; red 0 = 8'hC0.
- Change detect:
  - `prev_color` (4 bits) registers `color` every cycle.
  - `chg[k] = color[k] ^ prev_color[k]`.
- Blink timer:
  - 8-bit `blink_div` counts `clk_en` ticks 0..`BLINK_HALF`-1, then wraps.
  - The wrap cycle produces a one-cycle `blink_tick`.
- Flash state machine, per light, 3-bit `flash_cnt[k]`:
  - IDLE (`flash_cnt`=0): digit displayed normally.
  - On `chg[k]`: `flash_cnt[k]` <= `FLASH_LOAD`, from any state.
  - ACTIVE (`flash_cnt`!=0): decrements by 1 on `blink_tick`.
  - Digit blanked (`seg`=8'hFF, anode still driven) while `flash_cnt[k]` is even and nonzero; shown normally while odd.
  - Sequence is 6 blank, 5 show, 4 blank, 3 show, 2 blank, 1 show, 0 idle.
- Blanking and dp follow live `flash_cnt` and `color` at the cycle `seg` is loaded. Between `clk_en` ticks, `seg` is refreshed every cycle for the currently selected digit.

## Timing
- Reset (`rst`=0 at edge) sets:
  - `seg`=8'hFF, `an`=4'hF (all off), `scan_idx`=0, `blink_div`=0.
  - All `flash_cnt`=0.
  - `prev_color` <= `color`, so the first cycle after reset reports no change.
- First `clk_en` after reset release: `scan_idx`=1, `an`=4'b1101.
- Until that first `clk_en`, `an` stays 4'hF.
- Input to output latency: `time_in`/`color` change on the selected digit appears on `seg` one cycle later.
- Change detect: `color[k]` toggles at edge N. `chg` is seen at edge N+1, and `flash_cnt[k]`=6 after edge N+1.
- First blank phase is partial: it ends at the next `blink_tick`. Subsequent phases last exactly `BLINK_HALF` `clk_en` ticks.
- Simultaneous events:
  - `chg[k]` and `blink_tick` in the same cycle: reload wins, `flash_cnt`=6.
  - Changes on multiple lights in one cycle reload each independently.
- Color toggles mid-flash restart that light's sequence at 6.
- Reset mid-flash aborts all flashes immediately; outputs return to reset values the same edge.
- `time_in` value is never range-checked; all 16 codes map as above.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `color`=4'hF -> `seg`=8'hFF, `an`=4'hF. Release with no `clk_en` -> no flash started, `an` stays 4'hF.
- Scan wrap: `time_in`=16'h3210, `color`=0, 5 `clk_en` pulses -> `an`/`seg` sequence is 1101/F9, 1011/A4, 0111/B0, 1110/C0, 1101/F9.
- Green dp: `color`=4'b0001, `time_in[3:0]`=5, `scan_idx`=0 -> `seg`=8'h12 after `flash_cnt[0]` returns to 0.
  - In this case `color[0]` rose, so light 0 first completes its flash before `seg`=8'h12 is checked.
- Flash: `BLINK_HALF`=2, toggle `color[2]`, run `clk_en` continuously -> digit 2 reads FF/normal/FF/normal/FF/normal across `blink_tick`s, then steady normal. `flash_cnt[2]` reaches 0 after 6 `blink_tick`s.
- Retrigger: toggle `color[1]` again when `flash_cnt[1]`=3, in the same cycle as `blink_tick` -> `flash_cnt[1]`=6, not 2.
- Reset mid-flash: assert `rst`=0 while `flash_cnt[3]`=4 -> next edge gives all `flash_cnt`=0, `seg`=8'hFF, `an`=4'hF.
